// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a; the helper maps one priority level to one control set.
`timescale 1ns/1ps
package pipe_ctrl_pkg;

  // MDU sequencer states
  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  // Default EX occupancies of multiply and divide
  localparam int unsigned MUL_CYCLES_DEF = 4;
  localparam int unsigned DIV_CYCLES_DEF = 32;

  // MDU countdown width; 6 bits hold a load value of up to 63
  localparam int unsigned MDU_CNT_W = 6;
  typedef logic [MDU_CNT_W-1:0] mdu_cnt_t;

  // Stall statistics width
  localparam int unsigned STALL_CNT_W = 32;
  typedef logic [STALL_CNT_W-1:0] stall_cnt_t;

  // Exactly one of these applies per cycle, highest priority first
  typedef enum logic [2:0] {
    LVL_FREEZE = 3'd0,
    LVL_MDU    = 3'd1,
    LVL_HAZARD = 3'd2,
    LVL_BRANCH = 3'd3,
    LVL_NONE   = 3'd4
  } stall_lvl_e;

  // Per-stage control bundle driven to the pipeline registers
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic exmem_write;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_bubble;
    logic memwb_bubble;
  } stage_ctrl_t;

  // Countdown load value for an occupancy of 'cycles' EX cycles
  function automatic mdu_cnt_t mdu_load(input int unsigned cycles);
    return mdu_cnt_t'(cycles - 1);
  endfunction

  // Control set for a given priority level
  function automatic stage_ctrl_t stage_ctrl(input stall_lvl_e lvl);
    stage_ctrl_t c;
    c = '0;
    case (lvl)
      LVL_FREEZE: begin
        // Whole pipe frozen; WB still retires, so feed it a NOP
        c.memwb_bubble = 1'b1;
      end
      LVL_MDU: begin
        // EX held by the MDU; the stages behind it keep draining
        c.exmem_write  = 1'b1;
        c.exmem_bubble = 1'b1;
      end
      LVL_HAZARD: begin
        // Load-use: hold PC and IF/ID, push a NOP into EX
        c.idex_write   = 1'b1;
        c.exmem_write  = 1'b1;
        c.idex_bubble  = 1'b1;
      end
      LVL_BRANCH: begin
        // Taken branch: everything advances, wrong-path fetch squashed
        c.pc_write     = 1'b1;
        c.ifid_write   = 1'b1;
        c.idex_write   = 1'b1;
        c.exmem_write  = 1'b1;
        c.ifid_flush   = 1'b1;
      end
      default: begin
        c.pc_write     = 1'b1;
        c.ifid_write   = 1'b1;
        c.idex_write   = 1'b1;
        c.exmem_write  = 1'b1;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_mdu_seq.sv
// MDU sequencer: tracks EX occupancy of a multiply or divide with a countdown.
// Latency: hold/en/done are combinational; occupancy is MUL/DIV_CYCLES plus freeze cycles.
// Backpressure: freeze_i holds state and count; start_i is ignored while busy.
`timescale 1ns/1ps
module mdu_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic div_i,
  input  logic freeze_i,
  output logic hold_o,
  output logic en_o,
  output logic done_o
);

  localparam mdu_cnt_t MUL_LOAD = mdu_load(MUL_CYCLES);
  localparam mdu_cnt_t DIV_LOAD = mdu_load(DIV_CYCLES);
  localparam mdu_cnt_t CNT_ONE  = mdu_cnt_t'(1);

  mdu_state_e state_q, state_d;
  mdu_cnt_t   cnt_q, cnt_d;

  // State and countdown registers; reset aborts any operation in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, countdown and handshake outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_o  = 1'b0;
    en_o    = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      MDU_IDLE: begin
        // The first EX cycle of an op always holds the front end
        hold_o = start_i;
        en_o   = start_i && !freeze_i;
        // A start during a freeze is simply retried: EX keeps asserting it
        if (start_i && !freeze_i) begin
          cnt_d   = div_i ? DIV_LOAD : MUL_LOAD;
          state_d = MDU_BUSY;
        end
      end
      MDU_BUSY: begin
        hold_o = (cnt_q > CNT_ONE);
        en_o   = !freeze_i;
        if (!freeze_i) begin
          if (cnt_q > CNT_ONE) begin
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            // Final EX cycle: result valid, EX advances
            done_o  = 1'b1;
            cnt_d   = '0;
            state_d = MDU_IDLE;
          end
        end
      end
      default: begin
        state_d = MDU_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges memory, MDU, load-use and branch.
// Latency: all control outputs are combinational from inputs and registered state.
// Backpressure: an unacked data-memory request freezes every stage, including the MDU.
`timescale 1ns/1ps
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES  = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned MEM_TIMEOUT = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   hazard_i,
  input  logic                   branch_i,
  input  logic                   dmem_req_i,
  input  logic                   dmem_ack_i,
  input  logic                   mdu_start_i,
  input  logic                   mdu_div_i,
  output logic                   pc_write_o,
  output logic                   ifid_write_o,
  output logic                   idex_write_o,
  output logic                   exmem_write_o,
  output logic                   ifid_flush_o,
  output logic                   idex_bubble_o,
  output logic                   exmem_bubble_o,
  output logic                   memwb_bubble_o,
  output logic                   mdu_en_o,
  output logic                   mdu_done_o,
  output logic                   mem_timeout_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  // Wait counter is wide enough to hold MEM_TIMEOUT itself and parks there
  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  typedef logic [WAIT_W-1:0] wait_cnt_t;
  localparam wait_cnt_t  WAIT_MAX  = wait_cnt_t'(MEM_TIMEOUT);
  localparam wait_cnt_t  WAIT_LAST = wait_cnt_t'(MEM_TIMEOUT - 1);
  localparam wait_cnt_t  WAIT_ONE  = wait_cnt_t'(1);
  localparam stall_cnt_t STALL_MAX = '1;

  logic        mem_freeze;
  logic        mdu_hold;
  logic        mdu_en;
  logic        mdu_done;
  stall_lvl_e  lvl;
  stage_ctrl_t ctrl;

  wait_cnt_t   wait_q, wait_d;
  logic        timeout_q, timeout_hit;
  stall_cnt_t  stall_cnt_q;
  logic        stall_inc;

  assign mem_freeze = dmem_req_i && !dmem_ack_i;

  mdu_seq #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_mdu_seq (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (mdu_start_i),
    .div_i    (mdu_div_i),
    .freeze_i (mem_freeze),
    .hold_o   (mdu_hold),
    .en_o     (mdu_en),
    .done_o   (mdu_done)
  );

  // Pick the single highest-priority stall source; a suppressed branch stays in ID
  always_comb begin
    lvl = LVL_NONE;
    if (mem_freeze) begin
      lvl = LVL_FREEZE;
    end else if (mdu_hold) begin
      lvl = LVL_MDU;
    end else if (hazard_i) begin
      lvl = LVL_HAZARD;
    end else if (branch_i) begin
      lvl = LVL_BRANCH;
    end
  end

  // Map the level to stage controls; reset forces everything quiet
  always_comb begin
    ctrl = '0;
    if (!rst_i) begin
      ctrl = stage_ctrl(lvl);
    end
  end

  assign pc_write_o     = ctrl.pc_write;
  assign ifid_write_o   = ctrl.ifid_write;
  assign idex_write_o   = ctrl.idex_write;
  assign exmem_write_o  = ctrl.exmem_write;
  assign ifid_flush_o   = ctrl.ifid_flush;
  assign idex_bubble_o  = ctrl.idex_bubble;
  assign exmem_bubble_o = ctrl.exmem_bubble;
  assign memwb_bubble_o = ctrl.memwb_bubble;
  assign mdu_en_o       = mdu_en && !rst_i;
  assign mdu_done_o     = mdu_done && !rst_i;

  // Consecutive-wait count; this cycle is the N-th wait when wait_q == N-1
  always_comb begin
    wait_d      = '0;
    timeout_hit = 1'b0;
    if (mem_freeze) begin
      wait_d      = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_ONE;
      timeout_hit = (wait_q >= WAIT_LAST);
    end
  end

  assign mem_timeout_o = !rst_i && (timeout_q || timeout_hit);

  // Wait counter and sticky timeout flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      timeout_q <= timeout_q || timeout_hit;
    end
  end

  // Stall statistics include the current cycle and saturate at all-ones
  always_comb begin
    stall_inc   = !rst_i && !ctrl.pc_write;
    stall_cnt_o = stall_cnt_q;
    if (stall_inc && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_o = stall_cnt_q + stall_cnt_t'(1);
    end
  end

  // Commit the running stall count
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_o;
    end
  end

endmodule
